// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared types, constants and helpers for the audio level/pitch meter
//
// Contents:
//   NUM_CH, CODE_W   channel count (tags 1..7) and width of one published code
//   chan_t, code_t   channel tag and 3-bit code types
//   state_t          meter sequencer states
//   msb_index()      bit position of the highest set bit (0 for a zero input)
package meter_pkg;

    localparam int NUM_CH = 7;
    localparam int CODE_W = 3;

    typedef logic [2:0]        chan_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        ACCUM,
        QUANT,
        PUBLISH
    } state_t;

    function automatic int msb_index(input logic [31:0] value);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/meter_quant.sv
// rtl/meter_quant.sv - combinational peak/zero-crossing to 3-bit volume/frequency code quantizer
//
// Ports:
//   peak_i   in  DW     peak magnitude of one channel over a window
//   zc_i     in  ZC_W   zero-crossing count of the same channel
//   vol_o    out 3      log2-style volume code (peak >= 2^(DW-8) -> 1 ... )
//   freq_o   out 3      min(7, zc_i >> ZC_SHIFT)
module meter_quant
    import meter_pkg::*;
#(
    parameter int DW       = 16,
    parameter int ZC_W     = 10,
    parameter int ZC_SHIFT = 2
) (
    input  logic [DW-1:0]   peak_i,
    input  logic [ZC_W-1:0] zc_i,
    output code_t           vol_o,
    output code_t           freq_o
);

    int msb_k;
    int vol_raw;
    int zc_scaled;

    always_comb begin
        msb_k     = msb_index(32'(peak_i));
        vol_raw   = 0;
        if ((peak_i != '0) && (msb_k >= DW - 8)) begin
            vol_raw = msb_k - (DW - 9);
        end
        // A magnitude never reaches bit DW-1, so this clamp only guards odd DW choices.
        if (vol_raw > 7) begin
            vol_raw = 7;
        end
        vol_o = code_t'(vol_raw);

        zc_scaled = int'(zc_i >> ZC_SHIFT);
        freq_o    = (zc_scaled > 7) ? code_t'(7) : code_t'(zc_scaled);
    end

endmodule

// File: rtl/audio_meter.sv
// rtl/audio_meter.sv - per-channel peak/zero-crossing meter publishing packed 3-bit codes
//
// Measures peak magnitude and zero-crossing count of synth channels 1..7 over a fixed
// window, quantizes each channel through one shared meter_quant during QUANT, and
// publishes all codes at once with a one-cycle upd_o strobe.
//
// Ports:
//   clk           in   1    system clock
//   reset         in   1    synchronous, active-low reset
//   sample_valid  in   1    sample_ch/sample_data valid this cycle
//   sample_ch     in   3    channel tag 1..7 (0 ignored)
//   sample_data   in   DW   signed sample
//   play          in   8    per-channel active flags (bit 0 ignored)
//   vol_o         out  24   volume codes, channel c at [3c+2:3c], [2:0] = 0
//   freq_o        out  24   frequency codes, same packing
//   upd_o         out  1    pulse on the cycle vol_o/freq_o change
//
// Build option: AUDIO_METER_DECAY_EN - published volume falls at most one step per window.
module audio_meter
    import meter_pkg::*;
#(
    parameter int DW         = 16,
    parameter int WIN_CYCLES = 1_250_000,
    parameter int ZC_SHIFT   = 2,
    parameter int ZC_W       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [2:0]    sample_ch,
    input  logic [DW-1:0] sample_data,
    input  logic [7:0]    play,
    output logic [23:0]   vol_o,
    output logic [23:0]   freq_o,
    output logic          upd_o
);

    localparam int                CNT_W        = $clog2(WIN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(WIN_CYCLES - 1);
    localparam logic [DW-1:0]     MAG_MAX      = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]     SAMPLE_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [ZC_W-1:0]   ZC_MAX       = {ZC_W{1'b1}};

    // Per-channel arrays carry an unused slot 0 so the 3-bit tag indexes them directly.
    state_t            state_q, state_d;
    chan_t             qidx_q, qidx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     peak_q [0:NUM_CH];
    logic [DW-1:0]     peak_d [0:NUM_CH];
    logic [DW-1:0]     shadow_peak_q [0:NUM_CH];
    logic [DW-1:0]     shadow_peak_d [0:NUM_CH];
    logic [ZC_W-1:0]   zc_q [0:NUM_CH];
    logic [ZC_W-1:0]   zc_d [0:NUM_CH];
    logic [ZC_W-1:0]   shadow_zc_q [0:NUM_CH];
    logic [ZC_W-1:0]   shadow_zc_d [0:NUM_CH];
    logic [NUM_CH:0]   last_sign_q, last_sign_d;
    logic [NUM_CH:0]   seen_q, seen_d;
    logic [23:0]       stage_vol_q, stage_vol_d;
    logic [23:0]       stage_freq_q, stage_freq_d;
    logic [23:0]       vol_q, vol_d;
    logic [23:0]       freq_q, freq_d;
    logic              upd_q, upd_d;

    logic              wrap;
    logic              smp_hit;
    logic              smp_sign;
    logic [DW-1:0]     mag;
    code_t             q_vol, q_freq;
    code_t             new_vol, new_freq;
`ifdef AUDIO_METER_DECAY_EN
    code_t             old_vol;
`endif

    assign wrap     = (cnt_q == CNT_LAST);
    assign smp_sign = sample_data[DW-1];
    assign smp_hit  = sample_valid && (sample_ch != '0) && play[sample_ch];

    // The most negative sample has no positive twin; clamp it to full scale.
    always_comb begin
        mag = sample_data;
        if (sample_data == SAMPLE_MIN) begin
            mag = MAG_MAX;
        end else if (smp_sign) begin
            mag = -sample_data;
        end
    end

    meter_quant #(
        .DW       (DW),
        .ZC_W     (ZC_W),
        .ZC_SHIFT (ZC_SHIFT)
    ) u_quant (
        .peak_i (shadow_peak_q[qidx_q]),
        .zc_i   (shadow_zc_q[qidx_q]),
        .vol_o  (q_vol),
        .freq_o (q_freq)
    );

    always_comb begin
        state_d       = state_q;
        qidx_d        = qidx_q;
        cnt_d         = wrap ? '0 : cnt_q + CNT_W'(1);
        peak_d        = peak_q;
        shadow_peak_d = shadow_peak_q;
        zc_d          = zc_q;
        shadow_zc_d   = shadow_zc_q;
        last_sign_d   = last_sign_q;
        seen_d        = seen_q;
        stage_vol_d   = stage_vol_q;
        stage_freq_d  = stage_freq_q;
        vol_d         = vol_q;
        freq_d        = freq_q;
        upd_d         = 1'b0;
        new_vol       = q_vol;
        new_freq      = q_freq;
`ifdef AUDIO_METER_DECAY_EN
        old_vol       = '0;
`endif

        // Window boundary: hand the finished window to the shadow copy. The live
        // accumulators restart from zero so a sample on this cycle opens the new window.
        if (wrap) begin
            for (int c = 0; c <= NUM_CH; c++) begin
                shadow_peak_d[c] = peak_q[c];
                shadow_zc_d[c]   = zc_q[c];
                peak_d[c]        = '0;
                zc_d[c]          = '0;
            end
        end

        if (smp_hit) begin
            if (mag > peak_d[sample_ch]) begin
                peak_d[sample_ch] = mag;
            end
            if (seen_q[sample_ch] && (last_sign_q[sample_ch] != smp_sign)
                && (zc_d[sample_ch] != ZC_MAX)) begin
                zc_d[sample_ch] = zc_d[sample_ch] + ZC_W'(1);
            end
            last_sign_d[sample_ch] = smp_sign;
            seen_d[sample_ch]      = 1'b1;
        end

        case (state_q)
            ACCUM: begin
                if (wrap) begin
                    state_d = QUANT;
                    qidx_d  = chan_t'(1);
                end
            end
            QUANT: begin
`ifdef AUDIO_METER_DECAY_EN
                old_vol = vol_q[3*qidx_q +: CODE_W];
                if ((old_vol != '0) && ((old_vol - 1'b1) > new_vol)) begin
                    new_vol = old_vol - 1'b1;
                end
`endif
                // A channel that is not playing reads as silent and loses its history.
                if (!play[qidx_q]) begin
                    new_vol               = '0;
                    new_freq              = '0;
                    peak_d[qidx_q]        = '0;
                    zc_d[qidx_q]          = '0;
                    shadow_peak_d[qidx_q] = '0;
                    shadow_zc_d[qidx_q]   = '0;
                    seen_d[qidx_q]        = 1'b0;
                end
                stage_vol_d[3*qidx_q +: CODE_W]  = new_vol;
                stage_freq_d[3*qidx_q +: CODE_W] = new_freq;
                if (qidx_q == chan_t'(NUM_CH)) begin
                    state_d = PUBLISH;
                    vol_d   = stage_vol_d;
                    freq_d  = stage_freq_d;
                    upd_d   = 1'b1;
                end else begin
                    qidx_d  = qidx_q + chan_t'(1);
                end
            end
            PUBLISH: begin
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ACCUM;
            qidx_q       <= '0;
            cnt_q        <= '0;
            last_sign_q  <= '0;
            seen_q       <= '0;
            stage_vol_q  <= '0;
            stage_freq_q <= '0;
            vol_q        <= '0;
            freq_q       <= '0;
            upd_q        <= 1'b0;
            for (int c = 0; c <= NUM_CH; c++) begin
                peak_q[c]        <= '0;
                shadow_peak_q[c] <= '0;
                zc_q[c]          <= '0;
                shadow_zc_q[c]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            qidx_q        <= qidx_d;
            cnt_q         <= cnt_d;
            last_sign_q   <= last_sign_d;
            seen_q        <= seen_d;
            stage_vol_q   <= stage_vol_d;
            stage_freq_q  <= stage_freq_d;
            vol_q         <= vol_d;
            freq_q        <= freq_d;
            upd_q         <= upd_d;
            peak_q        <= peak_d;
            shadow_peak_q <= shadow_peak_d;
            zc_q          <= zc_d;
            shadow_zc_q   <= shadow_zc_d;
        end
    end

    assign vol_o  = vol_q;
    assign freq_o = freq_q;
    assign upd_o  = upd_q;

endmodule

// File: tb/tb_audio_meter.sv
// tb/tb_audio_meter.sv - scoreboard bench for audio_meter with a 64-cycle window
module tb_audio_meter;

    localparam int WIN = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [15:0] sample_data;
    logic [7:0]  play;
    logic [23:0] vol_o;
    logic [23:0] freq_o;
    logic        upd_o;

    always #5 clk = ~clk;

    audio_meter #(
        .DW         (16),
        .WIN_CYCLES (WIN),
        .ZC_SHIFT   (2),
        .ZC_W       (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .play         (play),
        .vol_o        (vol_o),
        .freq_o       (freq_o),
        .upd_o        (upd_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [23:0] vol;
        logic [23:0] freq;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [2:0]  ch;
        int          data;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];

    int          cyc;
    int          m_peak [8];
    int          m_zc   [8];
    int          s_peak [8];
    int          s_zc   [8];
    int          pub_vol[8];
    bit          m_last [8];
    bit          m_seen [8];
    logic [23:0] e_vol;
    logic [23:0] e_freq;

    function automatic int vol_code(input int p);
        int v;
        v = 0;
        for (int k = 0; k < 7; k++) begin
            if (p >= (256 << k)) v = k + 1;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_peak[i] = 0; m_zc[i] = 0; s_peak[i] = 0; s_zc[i] = 0;
            pub_vol[i] = 0; m_last[i] = 0; m_seen[i] = 0;
        end
        e_vol  = '0;
        e_freq = '0;
        exp_q.delete();
    endtask

    task automatic model_cycle(input logic v, input logic [2:0] ch, input int d);
        int off, c, mag, qv, qf;
        off = cyc % WIN;
        if (cyc >= WIN && off < 7) begin
            c  = off + 1;
            qv = vol_code(s_peak[c]);
            qf = s_zc[c] >> 2;
            if (qf > 7) qf = 7;
`ifdef AUDIO_METER_DECAY_EN
            if (pub_vol[c] - 1 > qv) qv = pub_vol[c] - 1;
`endif
            if (!play[c]) begin
                qv = 0; qf = 0;
                m_peak[c] = 0; m_zc[c] = 0; s_peak[c] = 0; s_zc[c] = 0; m_seen[c] = 0;
            end
            e_vol[3*c +: 3]  = 3'(qv);
            e_freq[3*c +: 3] = 3'(qf);
            pub_vol[c] = qv;
            if (c == 7) exp_q.push_back('{e_vol, e_freq});
        end
        if (off == WIN - 1) begin
            for (int i = 0; i < 8; i++) begin
                s_peak[i] = m_peak[i]; s_zc[i] = m_zc[i];
                m_peak[i] = 0; m_zc[i] = 0;
            end
        end
        if (v && ch != 0 && play[ch]) begin
            mag = (d < 0) ? -d : d;
            if (mag > 32767) mag = 32767;
            if (mag > m_peak[ch]) m_peak[ch] = mag;
            if (m_seen[ch] && (m_last[ch] != (d < 0)) && m_zc[ch] < 1023) m_zc[ch]++;
            m_last[ch] = (d < 0);
            m_seen[ch] = 1;
        end
    endtask

    task automatic tick(input logic v, input logic [2:0] ch, input int d);
        sample_valid = v;
        sample_ch    = ch;
        sample_data  = 16'(d);
        if (reset) model_cycle(v, ch, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int end_cyc);
        stim_t s;
        while (cyc < end_cyc) begin
            if (stim_q.size() > 0 && stim_q[0].cyc == cyc) begin
                s = stim_q.pop_front();
                tick(1'b1, s.ch, s.data);
            end else begin
                tick(1'b0, 3'd0, 0);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        play  = 8'h00;
        repeat (3) tick(1'b0, 3'd0, 0);
        model_reset();
        cyc   = 0;
        reset = 1'b1;
        check_eq({tag, "_vol"},  32'(vol_o),  32'h0);
        check_eq({tag, "_freq"}, 32'(freq_o), 32'h0);
        check_eq({tag, "_upd"},  32'(upd_o),  32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (upd_o) begin
            if (exp_q.size() == 0) begin
                check_eq("upd_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pub_vol",  32'(vol_o),  32'(e.vol));
                check_eq("pub_freq", 32'(freq_o), 32'(e.freq));
            end
        end
    end

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample_data  = '0;
        play         = '0;
        cyc          = 0;
        model_reset();
        do_reset("reset");

        // ch1 alternating full-ish scale, 12 samples -> 11 crossings
        for (int i = 0; i < 12; i++) begin
            stim_q.push_back('{80 + 2*i, 3'd1, (i % 2 == 0) ? 20000 : -20000});
        end
        // ch3 peak 300, ch7 most-negative sample, tag 0 and inactive ch5 ignored
        stim_q.push_back('{150, 3'd3, 300});
        stim_q.push_back('{152, 3'd3, -100});
        stim_q.push_back('{154, 3'd7, -32768});
        stim_q.push_back('{156, 3'd0, 30000});
        stim_q.push_back('{158, 3'd3, 200});
        stim_q.push_back('{160, 3'd5, 20000});
        // ch3 peak 255, ch2 active until play[2] drops
        stim_q.push_back('{210, 3'd3, 255});
        stim_q.push_back('{212, 3'd2, 10000});
        stim_q.push_back('{214, 3'd2, -10000});
        // sample on the wrap cycle of the window ending at 319
        stim_q.push_back('{319, 3'd5, 20000});

        play = 8'h02; run_until(136);
        play = 8'h8A; run_until(200);
        play = 8'h0E; run_until(240);
        play = 8'h0A; run_until(264);
        play = 8'h20; run_until(3 + 7*WIN);

        // reset lands four cycles after the wrap at 447, i.e. mid-quantization
        do_reset("midreset");
        run_until(WIN + 12);

        check_eq("pending_publishes", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
